// File: rtl/mpadd_pkg.sv
// Shared types and constants for the multi-precision adder scheduler.
// Holds the controller state encoding and the requester count.
package mpadd_pkg;

   // Controller states: waiting for a request, stepping slices, holding a result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of requesters sharing the slice adder.
   localparam int NUM_REQ = 2;

endpackage : mpadd_pkg

// File: rtl/mpadd_sched_if.sv
// Request/result bundle of the multi-precision adder scheduler.
// Optional feature macro: MPADD_SUB_EN (req_sub is only consumed when defined).
//
// Handshake rules (both channels):
//   - a transfer happens on a rising clk edge where valid & ready are both 1;
//   - the source holds valid and its payload until that transfer;
//   - req_ready is the arbiter grant: at most one bit set, only while idle;
//   - res_sum/res_cout/res_id stay constant while res_valid is high and
//     res_ready is low.
interface mpadd_sched_if
   import mpadd_pkg::*;
#(
   parameter int W = 32
);

   // Request side, one lane per requester.
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   logic [W-1:0]       req_a0;
   logic [W-1:0]       req_b0;
   logic [W-1:0]       req_a1;
   logic [W-1:0]       req_b1;
   logic [NUM_REQ-1:0] req_sub;

   // Result side.
   logic               res_valid;
   logic               res_ready;
   logic [W-1:0]       res_sum;
   logic               res_cout;
   logic               res_id;

   // Scheduler view.
   modport slave (
      input  req_valid,
      output req_ready,
      input  req_a0,
      input  req_b0,
      input  req_a1,
      input  req_b1,
`ifdef MPADD_SUB_EN
      input  req_sub,
`endif
      output res_valid,
      input  res_ready,
      output res_sum,
      output res_cout,
      output res_id
   );

   // Requester / result-consumer view.
   modport master (
      output req_valid,
      input  req_ready,
      output req_a0,
      output req_b0,
      output req_a1,
      output req_b1,
      output req_sub,
      input  res_valid,
      output res_ready,
      input  res_sum,
      input  res_cout,
      input  res_id
   );

endinterface : mpadd_sched_if

// File: rtl/mpadd_slice.sv
// N-bit ripple-carry adder slice built from an explicit full-adder chain.
// Purely combinational; the scheduler registers carry and sum around it.
module mpadd_slice #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   // Carry chain: c[0] is the slice carry-in, c[N] the slice carry-out.
   logic [N:0] c;

   assign c[0] = cin;

   // One full adder per bit: sum = a ^ b ^ c, carry = majority(a, b, c).
   for (genvar i = 0; i < N; i++) begin : g_fa
      logic axb;
      assign axb      = a[i] ^ b[i];
      assign sum[i]   = axb ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (axb & c[i]);
   end

   assign cout = c[N];

endmodule : mpadd_slice

// File: rtl/mpadd_sched.sv
// Multi-precision adder scheduler: two requesters share one N-bit slice.
// A W-bit operation is walked least significant slice first over W/N cycles,
// with the inter-slice carry held in a register.
// Optional feature macro: MPADD_SUB_EN (adds a - b via inverted b, carry-in 1).
module mpadd_sched
   import mpadd_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   mpadd_sched_if.slave bus,
   output state_t      dbg_state
);

   // Number of slice steps per operation and the slice index width.
   localparam int S  = W / N;
   localparam int KW = (S > 1) ? $clog2(S) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(S - 1);

   // Controller state and operation context.
   state_t             state;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       sum_q;
   logic [KW-1:0]      k_q;
   logic               carry_q;
   logic               id_q;
   logic               ptr_q;
   logic               res_valid_q;
`ifdef MPADD_SUB_EN
   logic               sub_q;
`endif

   // Arbitration signals.
   logic [NUM_REQ-1:0] grant;
   logic               gsel;

   // Slice datapath signals.
   logic [N-1:0]       a_sl;
   logic [N-1:0]       b_sl;
   logic [N-1:0]       s_sl;
   logic               c_out;

   // Round-robin grant: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      grant = '0;
      case (bus.req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
         default: grant = '0;
      endcase
   end

   assign gsel = grant[1];

   // Ready only while idle and out of reset, so nothing is accepted mid-operation.
   assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;

   // Select the current slice of both operands; subtraction inverts b.
   always_comb begin
      a_sl = a_q[k_q * N +: N];
      b_sl = b_q[k_q * N +: N];
`ifdef MPADD_SUB_EN
      if (sub_q) begin
         b_sl = ~b_q[k_q * N +: N];
      end
`endif
   end

   mpadd_slice #(
      .N (N)
   ) u_slice (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_q),
      .sum  (s_sl),
      .cout (c_out)
   );

   // Controller FSM: accept in IDLE, one slice per cycle in RUN, hold in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         k_q         <= '0;
         carry_q     <= 1'b0;
         id_q        <= 1'b0;
         ptr_q       <= 1'b0;
         res_valid_q <= 1'b0;
`ifdef MPADD_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  a_q   <= gsel ? bus.req_a1 : bus.req_a0;
                  b_q   <= gsel ? bus.req_b1 : bus.req_b0;
                  id_q  <= gsel;
                  ptr_q <= ~gsel;
                  k_q   <= '0;
`ifdef MPADD_SUB_EN
                  sub_q   <= gsel ? bus.req_sub[1] : bus.req_sub[0];
                  carry_q <= gsel ? bus.req_sub[1] : bus.req_sub[0];
`else
                  carry_q <= 1'b0;
`endif
                  state <= RUN;
               end
            end
            RUN: begin
               sum_q[k_q * N +: N] <= s_sl;
               carry_q             <= c_out;
               k_q                 <= k_q + 1'b1;
               if (k_q == K_LAST) begin
                  res_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               res_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   // Result outputs come straight from registers; the final carry is the carry out.
   assign bus.res_valid = res_valid_q;
   assign bus.res_sum   = sum_q;
   assign bus.res_cout  = carry_q;
   assign bus.res_id    = id_q;
   assign dbg_state     = state;

endmodule : mpadd_sched
